mode_sequencer: RTL and testbench
=================================

# mode_sequencer

Clocked front-panel controller for the DE10-Lite calculator datapath. It replaces the purely combinational KEY-to-MODE mapping. Each raw push-button is synchronized and debounced, and KEY[0] presses step MODE through arithmetic, logical, comparison and magic. KEY[1] presses latch the switch operands and OPERATION into registers, so the arithmetic/logical/comparison units and the HEX0/HEX1 result mux see stable inputs, together with a result-valid flag and a blink signal for the HEX5 mode digit.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a key level change (10 ms at 50 MHz).
- DB_W, 20: debounce counter width; must hold DEBOUNCE_CYCLES.
- BLINK_CYCLES, 12500000: half-period of BLINK, in cycles.
- BL_W, 24: blink counter width.

Ports:
- CLK, input, 1: 50 MHz board clock; all state on its rising edge.
- RST_N, input, 1: reset, asynchronous, active-low.
- KEY, input, 2: raw push-buttons, active-low (0 = pressed), asynchronous to CLK.
- SW, input, 10: raw slide switches.
- MODE, output, 2: selected module, 0 = arithmetic, 1 = logical, 2 = comparison, 3 = magic.
- OPERATION, output, 2: latched SW[9:8].
- X, output, 4: latched SW[3:0].
- Y, output, 4: latched SW[7:4].
- LOAD_STROBE, output, 1: one-cycle pulse in the cycle X/Y/OPERATION take new values.
- RESULT_VALID, output, 1: operands latched since the last mode change.
- BLINK, output, 1: mode-digit blink enable; the top blanks HEX5 when 1.

## Operation

Key path, one instance per KEY bit:
- Two-flop synchronizer, reset to 1.
- Debouncer: stable level `db`, reset to 1, and a counter `cnt`, reset to 0.
  - While the synchronized level equals `db`: `cnt` <= 0.
  - Otherwise: `cnt` increments. When `cnt` reaches DEBOUNCE_CYCLES-1 and the level still differs, `db` <= synchronized level and `cnt` <= 0.
  - Any reversion before that point clears `cnt`.
- Press event: registered one-cycle pulse on the `db` 1->0 transition. Release generates nothing.
- A held key produces exactly one event. The next event requires a debounced release and then a re-press.
- Internal pulses: `next_p` from KEY[0], `load_p` from KEY[1].

FSM, states SELECT and READY:
- SELECT: RESULT_VALID = 0, BLINK toggles.
- READY: RESULT_VALID = 1, BLINK = 0.
- `next_p` alone, from either state:
  - MODE <= MODE+1, modulo 4 (3 -> 0).
  - State -> SELECT; blink counter <= 0; BLINK <= 1.
- `load_p` alone, from either state:
  - X <= SW[3:0], Y <= SW[7:4], OPERATION <= SW[9:8].
  - LOAD_STROBE <= 1 for that cycle; state -> READY; BLINK <= 0.
  - Reloading in READY stays in READY and re-latches.
- `next_p` and `load_p` in the same cycle: apply both. MODE increments, operands latch, LOAD_STROBE pulses, state -> READY.
- Blink counter in SELECT:
  - Counts 0..BLINK_CYCLES-1.
  - On terminal count it wraps to 0 and BLINK toggles.
- Blink counter in READY: held at 0.
- SW changes never affect X/Y/OPERATION except on `load_p`.

Reset values (RST_N low, immediate and asynchronous):
- State SELECT; MODE = 0; OPERATION = 0; X = 0; Y = 0.
- LOAD_STROBE = 0; RESULT_VALID = 0; BLINK = 0; blink counter = 0.
- Synchronizers = 1, `db` = 1, `cnt` = 0.

Reset asserted mid-debounce or mid-press:
- All progress is discarded.
- A key still held when RST_N deasserts is seen as a fresh press after full debounce.

## Timing

- All outputs are registered; none are combinational from inputs.
- KEY steady low, first sampled at edge k:
  - Synchronizer output low at edge k+1.
  - `db` falls at edge k+1+DEBOUNCE_CYCLES.
  - Press pulse at edge k+2+DEBOUNCE_CYCLES.
  - MODE/X/Y/OPERATION/LOAD_STROBE/state update at edge k+3+DEBOUNCE_CYCLES.
  - Total latency: DEBOUNCE_CYCLES+3 edges.
- SW is sampled at the same edge the operands update. The top treats SW as quasi-static and it is not synchronized.
- In SELECT, BLINK period = 2 × BLINK_CYCLES cycles, 50% duty, first toggle BLINK_CYCLES cycles after entry.

## Test plan

All scenarios use DEBOUNCE_CYCLES = 4 and BLINK_CYCLES = 3.

- **Reset:** pulse RST_N low mid-simulation -> all outputs 0 immediately, MODE = 0, BLINK = 0, no LOAD_STROBE after release.
- **Mode wrap:** four clean KEY[0] presses (low 10 cycles, high 10 cycles) -> MODE 1, 2, 3, 0, each changing exactly 7 edges after the first low sample; RESULT_VALID stays 0.
- **Bounce rejection:** KEY[0] toggles low/high every 2 cycles for 20 cycles, then held high -> no MODE change. Then held low 6 cycles -> exactly one increment.
- **Load:** SW = 10'b10_0110_1011, KEY[1] press -> X = 4'hB, Y = 4'h6, OPERATION = 2, one-cycle LOAD_STROBE, RESULT_VALID = 1, BLINK = 0. Then change SW to 0 -> X/Y/OPERATION unchanged.
- **Simultaneous press:** from MODE = 1, both keys pressed on the same edge -> MODE = 2, operands latched, state READY, RESULT_VALID = 1.
- **Blink and held key:** in SELECT, BLINK = 1 on entry and toggles every 3 cycles. Then hold KEY[0] low 40 cycles -> single MODE increment. Then reset mid-hold and release reset with the key still low -> MODE = 0, then 1 after 7 edges.

Source files
------------

// File: rtl/mode_sequencer.sv
// mode_sequencer: clocked front-panel controller for the calculator datapath.
// Each push-button is synchronized, debounced and turned into a single press
// pulse. KEY[0] steps MODE, KEY[1] latches the switch operands. A two-state
// machine drives RESULT_VALID and the HEX5 blink enable.
module mode_sequencer #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int DB_W            = 20,
   parameter int BLINK_CYCLES    = 12500000,
   parameter int BL_W            = 24
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [1:0] KEY,
   input  logic [9:0] SW,
   output logic [1:0] MODE,
   output logic [1:0] OPERATION,
   output logic [3:0] X,
   output logic [3:0] Y,
   output logic       LOAD_STROBE,
   output logic       RESULT_VALID,
   output logic       BLINK
);

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);

   typedef enum logic [0:0] {
      ST_SELECT = 1'b0,
      ST_READY  = 1'b1
   } state_t;

   logic [1:0] press_s;
   logic       next_p_s;
   logic       load_p_s;

   genvar g;
   generate
      for (g = 0; g < 2; g++) begin : g_key
         logic            sync1_r;
         logic            sync2_r;
         logic            db_r;
         logic            db_d_r;
         logic            press_r;
         logic [DB_W-1:0] cnt_r;

         // synchronize the raw button, debounce its level and flag the 1->0 edge of the stable level
         always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
               sync1_r <= 1'b1;
               sync2_r <= 1'b1;
               db_r    <= 1'b1;
               db_d_r  <= 1'b1;
               press_r <= 1'b0;
               cnt_r   <= '0;
            end else begin
               sync1_r <= KEY[g];
               sync2_r <= sync1_r;
               db_d_r  <= db_r;
               press_r <= db_d_r & ~db_r;
               if (sync2_r == db_r) begin
                  cnt_r <= '0;
               end else if (cnt_r == DB_LAST) begin
                  db_r  <= sync2_r;
                  cnt_r <= '0;
               end else begin
                  cnt_r <= cnt_r + DB_W'(1);
               end
            end
         end

         assign press_s[g] = press_r;
      end
   endgenerate

   assign next_p_s = press_s[0];
   assign load_p_s = press_s[1];

   state_t          state_r;
   logic [1:0]      mode_r;
   logic [1:0]      operation_r;
   logic [3:0]      x_r;
   logic [3:0]      y_r;
   logic            load_strobe_r;
   logic            result_valid_r;
   logic            blink_r;
   logic [BL_W-1:0] blink_cnt_r;

   // mode stepping, operand latching, SELECT/READY state and the blink timer
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r        <= ST_SELECT;
         mode_r         <= 2'd0;
         operation_r    <= 2'd0;
         x_r            <= 4'd0;
         y_r            <= 4'd0;
         load_strobe_r  <= 1'b0;
         result_valid_r <= 1'b0;
         blink_r        <= 1'b0;
         blink_cnt_r    <= '0;
      end else begin
         load_strobe_r <= 1'b0;
         case ({next_p_s, load_p_s})
            2'b10: begin
               mode_r         <= mode_r + 2'd1;
               state_r        <= ST_SELECT;
               result_valid_r <= 1'b0;
               blink_cnt_r    <= '0;
               blink_r        <= 1'b1;
            end
            2'b01: begin
               x_r            <= SW[3:0];
               y_r            <= SW[7:4];
               operation_r    <= SW[9:8];
               load_strobe_r  <= 1'b1;
               state_r        <= ST_READY;
               result_valid_r <= 1'b1;
               blink_cnt_r    <= '0;
               blink_r        <= 1'b0;
            end
            2'b11: begin
               // both presses land together: step the mode and latch, ending in READY
               mode_r         <= mode_r + 2'd1;
               x_r            <= SW[3:0];
               y_r            <= SW[7:4];
               operation_r    <= SW[9:8];
               load_strobe_r  <= 1'b1;
               state_r        <= ST_READY;
               result_valid_r <= 1'b1;
               blink_cnt_r    <= '0;
               blink_r        <= 1'b0;
            end
            default: begin
               case (state_r)
                  ST_SELECT: begin
                     if (blink_cnt_r == BL_LAST) begin
                        blink_cnt_r <= '0;
                        blink_r     <= ~blink_r;
                     end else begin
                        blink_cnt_r <= blink_cnt_r + BL_W'(1);
                     end
                  end
                  ST_READY: begin
                     blink_cnt_r <= '0;
                     blink_r     <= 1'b0;
                  end
                  default: begin
                     state_r        <= ST_SELECT;
                     result_valid_r <= 1'b0;
                     blink_cnt_r    <= '0;
                     blink_r        <= 1'b0;
                  end
               endcase
            end
         endcase
      end
   end

   assign MODE         = mode_r;
   assign OPERATION    = operation_r;
   assign X            = x_r;
   assign Y            = y_r;
   assign LOAD_STROBE  = load_strobe_r;
   assign RESULT_VALID = result_valid_r;
   assign BLINK        = blink_r;

endmodule

// File: tb/tb_mode_sequencer.sv
// tb_mode_sequencer: scoreboard bench for mode_sequencer with short debounce
// and blink periods. Each key press pushes the expected output event (values
// and the edge on which it appears); a monitor pops and compares whenever MODE
// changes or LOAD_STROBE pulses.
module tb_mode_sequencer;

   logic       CLK;
   logic       RST_N;
   logic [1:0] KEY;
   logic [9:0] SW;
   logic [1:0] MODE;
   logic [1:0] OPERATION;
   logic [3:0] X;
   logic [3:0] Y;
   logic       LOAD_STROBE;
   logic       RESULT_VALID;
   logic       BLINK;

   mode_sequencer #(
      .DEBOUNCE_CYCLES(4),
      .DB_W(20),
      .BLINK_CYCLES(3),
      .BL_W(24)
   ) dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .KEY(KEY),
      .SW(SW),
      .MODE(MODE),
      .OPERATION(OPERATION),
      .X(X),
      .Y(Y),
      .LOAD_STROBE(LOAD_STROBE),
      .RESULT_VALID(RESULT_VALID),
      .BLINK(BLINK)
   );

   typedef struct {
      logic [1:0] mode;
      logic       strobe;
      logic [3:0] x;
      logic [3:0] y;
      logic [1:0] op;
      logic       rv;
      logic       blink;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int events_seen = 0;
   int events_pushed = 0;

   logic [1:0] m_mode;
   logic [3:0] m_x;
   logic [3:0] m_y;
   logic [1:0] m_op;
   logic       m_rv;
   logic       m_blink;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_mode"}, 32'(MODE), 32'd0);
      check_eq({tag, "_op"}, 32'(OPERATION), 32'd0);
      check_eq({tag, "_x"}, 32'(X), 32'd0);
      check_eq({tag, "_y"}, 32'(Y), 32'd0);
      check_eq({tag, "_strobe"}, 32'(LOAD_STROBE), 32'd0);
      check_eq({tag, "_rv"}, 32'(RESULT_VALID), 32'd0);
      check_eq({tag, "_blink"}, 32'(BLINK), 32'd0);
   endtask

   // press the keys in mask, update the model and queue the expected event
   task automatic drive_press(input logic [1:0] mask, output int k);
      exp_t e;
      KEY = ~mask;
      k = cyc + 1;
      if (mask[0]) m_mode = m_mode + 2'd1;
      if (mask[1]) begin
         m_x = SW[3:0];
         m_y = SW[7:4];
         m_op = SW[9:8];
         m_rv = 1'b1;
         m_blink = 1'b0;
      end else begin
         m_rv = 1'b0;
         m_blink = 1'b1;
      end
      e.mode = m_mode;
      e.strobe = mask[1];
      e.x = m_x;
      e.y = m_y;
      e.op = m_op;
      e.rv = m_rv;
      e.blink = m_blink;
      e.cyc = k + 7;
      exp_q.push_back(e);
      events_pushed++;
   endtask

   task automatic press_clean(input logic [1:0] mask, input int lo, input int hi);
      int k;
      drive_press(mask, k);
      repeat (lo) @(negedge CLK);
      KEY = 2'b11;
      repeat (hi) @(negedge CLK);
   endtask

   task automatic model_reset();
      m_mode = 2'd0;
      m_x = 4'd0;
      m_y = 4'd0;
      m_op = 2'd0;
      m_rv = 1'b0;
      m_blink = 1'b0;
   endtask

   // output monitor: any MODE change or LOAD_STROBE is an event to score
   initial begin
      logic [1:0] prev_mode;
      exp_t e;
      prev_mode = 2'd0;
      forever begin
         @(negedge CLK);
         if (RST_N === 1'b1 && (LOAD_STROBE !== 1'b0 || MODE !== prev_mode)) begin
            events_seen++;
            if (exp_q.size() == 0) begin
               check_eq("unexpected_event", 32'(events_seen), 32'(events_pushed));
            end else begin
               e = exp_q.pop_front();
               check_eq("ev_cycle", 32'(cyc), 32'(e.cyc));
               check_eq("ev_mode", 32'(MODE), 32'(e.mode));
               check_eq("ev_strobe", 32'(LOAD_STROBE), 32'(e.strobe));
               check_eq("ev_x", 32'(X), 32'(e.x));
               check_eq("ev_y", 32'(Y), 32'(e.y));
               check_eq("ev_op", 32'(OPERATION), 32'(e.op));
               check_eq("ev_rv", 32'(RESULT_VALID), 32'(e.rv));
               check_eq("ev_blink", 32'(BLINK), 32'(e.blink));
            end
         end
         prev_mode = MODE;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      RST_N = 1'b0;
      KEY = 2'b11;
      SW = 10'd0;
      model_reset();
      repeat (3) @(negedge CLK);
      #1;
      check_outputs_zero("reset_init");
      @(negedge CLK);
      #2 RST_N = 1'b1;
      repeat (5) @(negedge CLK);

      // four clean presses wrap MODE 1,2,3,0
      for (int i = 0; i < 4; i++) press_clean(2'b01, 10, 10);

      // bounce shorter than the debounce window is ignored
      for (int i = 0; i < 5; i++) begin
         KEY[0] = 1'b0;
         repeat (2) @(negedge CLK);
         KEY[0] = 1'b1;
         repeat (2) @(negedge CLK);
      end
      repeat (10) @(negedge CLK);
      check_eq("bounce_mode", 32'(MODE), 32'd0);
      press_clean(2'b01, 6, 10);

      // operand load, then switches move without effect
      SW = 10'b10_0110_1011;
      press_clean(2'b10, 10, 10);
      SW = 10'd0;
      repeat (5) @(negedge CLK);
      check_eq("hold_x", 32'(X), 32'hB);
      check_eq("hold_y", 32'(Y), 32'h6);
      check_eq("hold_op", 32'(OPERATION), 32'd2);
      check_eq("ready_rv", 32'(RESULT_VALID), 32'd1);
      check_eq("ready_blink", 32'(BLINK), 32'd0);

      // both keys on the same edge from MODE 1
      SW = 10'b01_1100_0101;
      press_clean(2'b11, 10, 10);
      check_eq("simul_rv", 32'(RESULT_VALID), 32'd1);
      check_eq("simul_mode", 32'(MODE), 32'd2);

      // held key: one step, BLINK 1 on entry and toggling every 3 cycles
      drive_press(2'b01, k);
      while (cyc < k + 7) @(negedge CLK);
      for (int j = 0; j < 7; j++) begin
         check_eq("blink_seq", 32'(BLINK), ((j / 3) % 2 == 0) ? 32'd1 : 32'd0);
         @(negedge CLK);
      end
      check_eq("select_rv", 32'(RESULT_VALID), 32'd0);
      repeat (26) @(negedge CLK);
      KEY = 2'b11;
      repeat (12) @(negedge CLK);
      check_eq("held_mode", 32'(MODE), 32'd3);

      // load nonzero operands, then reset in the middle of a held press
      SW = 10'h3FF;
      press_clean(2'b10, 10, 10);
      drive_press(2'b01, k);
      repeat (3) @(negedge CLK);
      #2 RST_N = 1'b0;
      exp_q.delete();
      events_pushed = events_seen;
      model_reset();
      #1;
      check_outputs_zero("reset_mid");
      repeat (2) @(negedge CLK);
      #2 RST_N = 1'b1;
      drive_press(2'b01, k);
      @(negedge CLK);
      check_eq("post_rst_strobe", 32'(LOAD_STROBE), 32'd0);
      check_eq("post_rst_mode", 32'(MODE), 32'd0);

      for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge CLK);
      check_eq("queue_drain", 32'(exp_q.size()), 32'd0);
      check_eq("final_mode", 32'(MODE), 32'd1);
      KEY = 2'b11;
      repeat (12) @(negedge CLK);
      check_eq("final_strobe", 32'(LOAD_STROBE), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
